// File: rtl/stream_sched_pkg.sv
// Shared types and widths for the stream pair scheduler.
// Optional sequence checking is enabled with STREAM_SEQ_CHECK_EN.
package stream_sched_pkg;

    localparam int DATA_W    = 32;
    localparam int HALF_W    = 16;
    localparam int CNT_W_DEF = 16;

    // IDLE: no burst; FETCH: waiting for a word; HIGH: strobe cycle; LOW: hold cycle
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] next_seq(input logic [DATA_W-1:0] w);
        return w + DATA_W'(1);
    endfunction

endpackage

// File: rtl/stream_seq_check.sv
// Flags a break in the +1 word sequence of captured words.
// Only instantiated when STREAM_SEQ_CHECK_EN is defined.
module stream_seq_check
    import stream_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              capture,
    input  logic [DATA_W-1:0] data,
    output logic              seq_err
);

    logic              have_ref;
    logic [DATA_W-1:0] prev_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_ref  <= 1'b0;
            prev_word <= '0;
            seq_err   <= 1'b0;
        end else if (clear) begin
            // First capture after clear becomes the reference word
            have_ref  <= 1'b0;
            prev_word <= '0;
            seq_err   <= 1'b0;
        end else if (capture) begin
            have_ref  <= 1'b1;
            prev_word <= data;
            if (have_ref && (data != next_seq(prev_word))) begin
                seq_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_pair_scheduler.sv
// Paces 32-bit generator words into a 32-to-16 adapter: each word is held two
// clocks with a strobe on the first. STREAM_SEQ_CHECK_EN adds the seq_err output.
module stream_pair_scheduler
    import stream_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              abort,
    input  logic [DATA_W-1:0] gen_data,
    input  logic              gen_valid,
    output logic              gen_ack,
    input  logic              fifo_afull,
    output logic [DATA_W-1:0] stream_32,
    output logic              num_32_rdy,
    output logic              busy,
    output logic              done,
`ifdef STREAM_SEQ_CHECK_EN
    output logic              seq_err,
`endif
    output logic [CNT_W-1:0]  words_sent
);

    // Handshake: gen_ack is high only in a cycle where gen_data is captured;
    // the generator treats gen_valid && gen_ack at a rising edge as a pop.
    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] sent_inc;
    logic             last_word;
    logic             can_take;

    assign sent_inc  = words_sent + CNT_W'(1);
    assign last_word = (sent_inc == len_q);
    assign can_take  = gen_valid && !fifo_afull && !abort;

    always_comb begin
        gen_ack = 1'b0;
        case (state)
            FETCH:   gen_ack = can_take;
            LOW:     gen_ack = can_take && !last_word;
            default: gen_ack = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            stream_32  <= '0;
            num_32_rdy <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            words_sent <= '0;
        end else begin
            num_32_rdy <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            len_q      <= burst_len;
                            words_sent <= '0;
                            busy       <= 1'b1;
                            state      <= FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (gen_ack) begin
                        stream_32  <= gen_data;
                        num_32_rdy <= 1'b1;
                        state      <= HIGH;
                    end
                end
                HIGH: begin
                    // A word is never split: LOW always follows
                    state <= LOW;
                end
                LOW: begin
                    words_sent <= sent_inc;
                    if (last_word || abort) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (gen_ack) begin
                        stream_32  <= gen_data;
                        num_32_rdy <= 1'b1;
                        state      <= HIGH;
                    end else begin
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STREAM_SEQ_CHECK_EN
    stream_seq_check u_seq_check (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   ((state == IDLE) && start),
        .capture (gen_ack),
        .data    (gen_data),
        .seq_err (seq_err)
    );
`endif

endmodule

// File: tb/tb_stream_pair_scheduler.sv
// Randomized bench for stream_pair_scheduler against a word-progress reference
// model; STREAM_SEQ_CHECK_EN also exercises seq_err.
module tb_stream_pair_scheduler;
  import stream_sched_pkg::*;

  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              start;
  logic [CNT_W-1:0]  burst_len;
  logic              abort;
  logic [DATA_W-1:0] gen_data;
  logic              gen_valid;
  logic              gen_ack;
  logic              fifo_afull;
  logic [DATA_W-1:0] stream_32;
  logic              num_32_rdy;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  words_sent;
`ifdef STREAM_SEQ_CHECK_EN
  logic              seq_err;
`endif

  stream_pair_scheduler #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .burst_len  (burst_len),
    .abort      (abort),
    .gen_data   (gen_data),
    .gen_valid  (gen_valid),
    .gen_ack    (gen_ack),
    .fifo_afull (fifo_afull),
    .stream_32  (stream_32),
    .num_32_rdy (num_32_rdy),
    .busy       (busy),
    .done       (done),
`ifdef STREAM_SEQ_CHECK_EN
    .seq_err    (seq_err),
`endif
    .words_sent (words_sent)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Word progress: pos 0 = waiting for a word, 1 = strobe clock, 2 = hold clock
  bit                m_busy;
  int                m_len;
  int                m_sent;
  int                m_pos;
  logic [DATA_W-1:0] m_stream;
  bit                m_rdy;
  bit                m_done;
  bit                m_err;
  bit                m_have_ref;
  logic [DATA_W-1:0] m_prev;
  logic [DATA_W-1:0] exp_q[$];

  logic [DATA_W-1:0] src [0:63];
  int                gen_ptr;
  int                ack_count;
  int                rdy_count;
  bit                prev_rdy;
  logic [DATA_W-1:0] prev_stream;

  task automatic model_reset();
    m_busy = 0; m_len = 0; m_sent = 0; m_pos = 0;
    m_stream = '0; m_rdy = 0; m_done = 0;
    m_err = 0; m_have_ref = 0; m_prev = '0;
    exp_q.delete();
    prev_rdy = 0; prev_stream = '0;
  endtask

  function automatic bit model_ack();
    if (!m_busy || !gen_valid || fifo_afull || abort) return 0;
    if (m_pos == 0) return 1;
    if (m_pos == 2 && (m_sent + 1) != m_len) return 1;
    return 0;
  endfunction

  task automatic model_take();
    m_stream = gen_data;
    m_pos    = 1;
    m_rdy    = 1;
    exp_q.push_back(gen_data);
    if (m_have_ref && gen_data != m_prev + 32'd1) m_err = 1;
    m_prev     = gen_data;
    m_have_ref = 1;
  endtask

  task automatic model_step();
    bit ack;
    ack    = model_ack();
    m_done = 0;
    m_rdy  = 0;
    if (!m_busy) begin
      if (start) begin
        m_err = 0; m_have_ref = 0;
        if (burst_len != 0) begin
          m_busy = 1; m_len = int'(burst_len); m_sent = 0; m_pos = 0;
        end else begin
          m_done = 1;
        end
      end
    end else if (m_pos == 0) begin
      if (abort) begin
        m_busy = 0; m_done = 1;
      end else if (ack) begin
        model_take();
      end
    end else if (m_pos == 1) begin
      m_pos = 2;
    end else begin
      m_sent++;
      if (m_sent == m_len || abort) begin
        m_busy = 0; m_done = 1; m_pos = 0;
      end else if (ack) begin
        model_take();
      end else begin
        m_pos = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("stream_32", stream_32, m_stream);
    check_val("num_32_rdy", num_32_rdy, m_rdy);
    check_val("busy", busy, m_busy);
    check_val("done", done, m_done);
    check_val("words_sent", words_sent, m_sent[CNT_W-1:0]);
`ifdef STREAM_SEQ_CHECK_EN
    check_val("seq_err", seq_err, m_err);
`endif
    if (num_32_rdy) begin
      rdy_count++;
      check_val("rdy_gap", prev_rdy, 0);
      if (exp_q.size() == 0) check_val("sb_underflow", 1, 0);
      else check_val("sb_word", stream_32, exp_q.pop_front());
    end
    if (prev_rdy) check_val("low_hold", stream_32, prev_stream);
    prev_rdy    = num_32_rdy;
    prev_stream = stream_32;
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    bit a;
    #1;
    a = gen_ack;
    check_val("gen_ack", gen_ack, model_ack());
    @(posedge clk);
    model_step();
    if (a) begin
      gen_ptr++;
      ack_count++;
    end
    @(negedge clk);
    check_outputs();
    gen_data = src[gen_ptr % 64];
  endtask

  task automatic load_src(input logic [DATA_W-1:0] base, input bit rnd);
    for (int i = 0; i < 64; i++) src[i] = rnd ? $urandom() : base + DATA_W'(i);
    gen_ptr  = 0;
    gen_data = src[0];
  endtask

  task automatic pulse_start(input int len);
    start     = 1;
    burst_len = CNT_W'(len);
    step();
    start     = 0;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n;
    n = 0;
    while (m_busy && n < max_cycles) begin
      step();
      n++;
    end
    check_val("idle_timeout", m_busy, 0);
  endtask

  task automatic run_until_pos(input int sent, input int pos, input int max_cycles);
    int n;
    n = 0;
    while (!(m_sent == sent && m_pos == pos) && n < max_cycles) begin
      step();
      n++;
    end
    check_val("pos_timeout", (m_sent == sent && m_pos == pos), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_stream"}, stream_32, 0);
    check_val({tag, "_rdy"}, num_32_rdy, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_sent"}, words_sent, 0);
    check_val({tag, "_ack"}, gen_ack, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] halves [$];
  logic [15:0] exp_halves [0:7];
  logic [15:0] rdy_mask;
  logic [15:0] done_mask;
  int          acks0;

  initial begin
    rst_n = 0; start = 0; burst_len = '0; abort = 0;
    gen_valid = 0; fifo_afull = 0; gen_data = '0;
    ack_count = 0; rdy_count = 0;
    model_reset();
    load_src(32'h0, 0);
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1;

    // Full rate: strobes at cycles 2,4,6,8 after start, done at 10
    src[0] = 32'h11112222; src[1] = 32'h33334444;
    src[2] = 32'h55556666; src[3] = 32'h77778888;
    gen_ptr = 0; gen_data = src[0];
    gen_valid = 1;
    rdy_mask = '0; done_mask = '0;
    halves.delete();
    start = 1; burst_len = 4;
    for (int k = 1; k <= 12; k++) begin
      step();
      start = 0;
      rdy_mask[k]  = num_32_rdy;
      done_mask[k] = done;
      if (num_32_rdy) halves.push_back(stream_32[31:16]);
      else if (k > 1 && rdy_mask[k-1]) halves.push_back(stream_32[15:0]);
    end
    check_val("fr_rdy_cycles", rdy_mask, 16'h0154);
    check_val("fr_done_cycle", done_mask, 16'h0400);
    check_val("fr_words_sent", words_sent, 4);
    exp_halves[0] = 16'h1111; exp_halves[1] = 16'h2222; exp_halves[2] = 16'h3333;
    exp_halves[3] = 16'h4444; exp_halves[4] = 16'h5555; exp_halves[5] = 16'h6666;
    exp_halves[6] = 16'h7777; exp_halves[7] = 16'h8888;
    check_val("fr_half_count", halves.size(), 8);
    for (int i = 0; i < 8 && i < halves.size(); i++) check_val("fr_half", halves[i], exp_halves[i]);

    // Backpressure after word 1
    load_src(32'hA000_0000, 0);
    pulse_start(3);
    run_until_pos(0, 1, 10);
    fifo_afull = 1;
    acks0 = ack_count;
    rdy_count = 0;
    repeat (5) step();
    check_val("bp_no_ack", ack_count - acks0, 0);
    check_val("bp_no_rdy", rdy_count, 0);
    fifo_afull = 0;
    run_until_idle(20);
    check_val("bp_words_sent", words_sent, 3);

    // Abort during HIGH of word 2
    load_src(32'hB000_0000, 0);
    pulse_start(10);
    run_until_pos(1, 1, 10);
    abort = 1;
    step();
    check_val("ab_high_busy", busy, 1);
    step();
    abort = 0;
    check_val("ab_words_sent", words_sent, 2);
    check_val("ab_done", done, 1);
    check_val("ab_busy", busy, 0);
    step();
    check_val("ab_done_once", done, 0);

    // Zero-length burst
    acks0 = ack_count;
    pulse_start(0);
    check_val("zl_done", done, 1);
    step();
    check_val("zl_done_once", done, 0);
    check_val("zl_no_ack", ack_count - acks0, 0);

    // Start while busy is ignored
    load_src(32'hC000_0000, 0);
    pulse_start(5);
    repeat (3) step();
    pulse_start(2);
    run_until_idle(30);
    check_val("sb_ignored_len", words_sent, 5);

    // Async reset during LOW of word 5
    load_src(32'hD000_0000, 0);
    pulse_start(8);
    run_until_pos(4, 2, 30);
    #2 rst_n = 0;
    #1;
    check_all_zero("areset");
    model_reset();
    @(negedge clk);
    check_all_zero("areset_hold");
    rst_n = 1;
    load_src(32'hE000_0000, 0);
    pulse_start(3);
    check_val("rs_sent_clear", words_sent, 0);
    run_until_idle(20);
    check_val("rs_words_sent", words_sent, 3);

`ifdef STREAM_SEQ_CHECK_EN
    // Sequence break: 0,1,2,4
    src[0] = 0; src[1] = 1; src[2] = 2; src[3] = 4;
    gen_ptr = 0; gen_data = src[0];
    pulse_start(4);
    run_until_idle(20);
    check_val("seq_err_set", seq_err, 1);
    load_src(32'h10, 0);
    pulse_start(2);
    check_val("seq_err_clear", seq_err, 0);
    run_until_idle(20);
    check_val("seq_err_ok", seq_err, 0);
`endif

    // Randomized bursts
    load_src(32'h0, 1);
    for (int b = 0; b < 25; b++) begin
      int n;
      if (b % 2 == 1) load_src(32'h100 * b, 0);
      abort = ($urandom_range(0, 4) == 0);
      gen_valid = $urandom_range(0, 3) != 0;
      fifo_afull = $urandom_range(0, 4) == 0;
      pulse_start($urandom_range(0, 6));
      n = 0;
      while (m_busy && n < 200) begin
        gen_valid  = $urandom_range(0, 3) != 0;
        fifo_afull = $urandom_range(0, 4) == 0;
        abort      = $urandom_range(0, 29) == 0;
        if ($urandom_range(0, 15) == 0) begin
          start = 1;
          burst_len = CNT_W'($urandom_range(1, 9));
        end
        step();
        start = 0;
        n++;
      end
      check_val("rnd_timeout", m_busy, 0);
      abort = 0;
      step();
    end

    check_val("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
